// File: rtl/uart_rx_param_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : uart_rx_param_if
//  Purpose  : Word-delivery bundle of the UART receiver. The receiver
//             presents a word with its error flags and a valid strobe. The
//             consumer answers with ready. busy reports frame activity.
//  Ports    : data[DATA_BITS], valid, parity_err, frame_err, overrun, busy
//             are driven by the receiver (master). ready is driven by the
//             consumer (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output data, valid, parity_err, frame_err, overrun, busy,
    input  ready
  );

  modport slave (
    input  data, valid, parity_err, frame_err, overrun, busy,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : uart_rx_param
//  Purpose  : Parameterised UART receiver. The receiver synchronises rx and
//             times every sample from the start edge. It assembles the data
//             bits and checks the optional parity and the stop bits. It
//             then delivers the word through a valid/ready holding register.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             rx   - serial line (idle high, asynchronous to clk)
//             bus  - master side of uart_rx_param_if
//                    (data, valid, ready, parity_err, frame_err, overrun, busy)
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 20,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        rx,
  uart_rx_param_if.master  bus
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);

  localparam logic [c_cnt_w-1:0] c_half_m1   = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full_m1   = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [3:0]         c_last_data = 4'(DATA_BITS - 1);
  localparam logic [3:0]         c_last_stop = 4'(STOP_BITS - 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [2:0]           r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_pe_acc;
  logic                 r_fe_acc;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic                 w_tick_half;
  logic                 w_tick_full;
  logic                 w_done;
  logic                 w_par_calc;
  logic                 w_par_err;
  logic [DATA_BITS-1:0] w_shift_next;

  // Sample points sit mid-bit. START waits half a bit and every later state
  // waits one whole bit after the previous sample.
  assign w_tick_half = (r_cnt == c_half_m1);
  assign w_tick_full = (r_cnt == c_full_m1);

  // The frame completes on the sample of its last stop bit.
  assign w_done = (r_state == c_st_stop) && w_tick_full && (r_idx == c_last_stop);

  // The held shift register is the complete word by the time the parity bit
  // is sampled.
  assign w_par_calc = (^r_shift) ^ r_rx_s;
  assign w_par_err  = (PARITY == 2) ? ~w_par_calc : w_par_calc;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shift_next = {r_shift[DATA_BITS-2:0], r_rx_s};
    end else begin : g_lsb_first
      assign w_shift_next = {r_rx_s, r_shift[DATA_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta    <= 1'b1;
      r_rx_s       <= 1'b1;
      r_state      <= c_st_idle;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_pe_acc     <= 1'b0;
      r_fe_acc     <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;

      case (r_state)
        c_st_idle: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (!r_rx_s) begin
            r_state  <= c_st_start;
            r_pe_acc <= 1'b0;
            r_fe_acc <= 1'b0;
          end
        end

        c_st_start: begin
          if (w_tick_half) begin
            r_cnt   <= '0;
            // A line already back high at mid-start was a glitch.
            r_state <= r_rx_s ? c_st_idle : c_st_data;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        c_st_data: begin
          if (w_tick_full) begin
            r_cnt   <= '0;
            r_shift <= w_shift_next;
            if (r_idx == c_last_data) begin
              r_idx   <= '0;
              r_state <= (PARITY != 0) ? c_st_parity : c_st_stop;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        c_st_parity: begin
          if (w_tick_full) begin
            r_cnt    <= '0;
            r_pe_acc <= w_par_err;
            r_state  <= c_st_stop;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        c_st_stop: begin
          if (w_tick_full) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_fe_acc <= 1'b1;
            end
            if (r_idx == c_last_stop) begin
              // Returning now lets a start edge in the next cycle be seen.
              r_idx   <= '0;
              r_state <= c_st_idle;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        default: begin
          r_state <= c_st_idle;
          r_cnt   <= '0;
          r_idx   <= '0;
        end
      endcase

      // A new word always wins over the held one. An unaccepted held word
      // is lost, and overrun flags that loss.
      if (w_done) begin
        r_data       <= r_shift;
        r_parity_err <= r_pe_acc;
        r_frame_err  <= r_fe_acc | ~r_rx_s;
        r_overrun    <= r_valid & ~bus.ready;
        r_valid      <= 1'b1;
      end else begin
        r_overrun <= 1'b0;
        if (r_valid && bus.ready) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.data       = r_data;
  assign bus.valid      = r_valid;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLKS_PER_BIT, default 20: clk cycles per serial bit; legal range >= 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; legal range 1..2.
REQ-005 Parameter MSB_FIRST, default 0: 0 = LSB received first, 1 = MSB received first.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 rx  input  1  serial line; idle high; asynchronous to clk.
REQ-009 data  output  DATA_BITS  received word.
REQ-010 valid  output  1  data/flags hold a word not yet accepted.
REQ-011 ready  input  1  consumer accepts the word when valid && ready.
REQ-012 parity_err  output  1  parity mismatch for the held word; 0 when PARITY=0.
REQ-013 frame_err  output  1  at least one stop bit sampled low for the held word.
REQ-014 overrun  output  1  one-cycle pulse when an unaccepted word is overwritten.
REQ-015 busy  output  1  high while the FSM is not in IDLE.

Function
REQ-016 rx shall pass through a 2-flop synchronizer; the FSM shall use only stage 2 (rx_s).
REQ-017 The FSM shall have states IDLE, START, DATA, PARITY and STOP, with one bit-period counter and one bit index.
REQ-018 In IDLE, the first cycle with rx_s=0 (cycle t0) shall move the FSM to START and clear the counter.
REQ-019 In START, the FSM shall sample rx_s at t0+CLKS_PER_BIT/2 (integer floor): if 1, return to IDLE with no output (glitch reject); if 0, go to DATA.
REQ-020 The FSM shall sample data bit i (i=0..DATA_BITS-1) at t0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT and shift it in per MSB_FIRST.
REQ-021 After the last data bit, the FSM shall go to PARITY if PARITY!=0, otherwise to STOP.
REQ-022 PARITY shall sample one bit period later; the error is: even, XOR(data, bit)=1; odd, XOR(data, bit)=0.
REQ-023 STOP shall sample each stop bit one period apart; any 0 shall set the frame error.
REQ-024 At the cycle of the last stop sample, the FSM shall return to IDLE so that a start edge in the following cycle is detected.
REQ-025 A completed frame shall load data, parity_err and frame_err, and valid shall be 1 the next cycle; 8N1 with CLKS_PER_BIT=20 gives valid at t0+191.
REQ-026 Words with errors shall still be delivered, with their flags.
REQ-027 Once loaded, data, flags and valid shall hold until valid && ready; valid shall fall the cycle after acceptance unless a new word loads in that same cycle.
REQ-028 If a frame completes while valid=1 and ready=0, the new word shall overwrite the held one, overrun shall pulse 1 cycle, and valid shall stay 1.
REQ-029 If acceptance and a completion coincide, the new word shall load, valid shall stay 1, and overrun shall stay 0.
REQ-030 busy = (state != IDLE).

Reset
REQ-031 rst=1 shall, on the next clk edge, set the FSM to IDLE and clear the counter and bit index.
REQ-032 rst=1 shall, on the next clk edge, set data=0, valid=0, parity_err=0, frame_err=0, overrun=0 and busy=0.
REQ-033 rst=1 shall preset both synchronizer flops to 1 (line idle).
REQ-034 Reset mid-frame shall abandon the frame with no output; reception shall resume at the next falling edge after rst=0.

Verification
REQ-035 8N1, CLKS_PER_BIT=20, ready=1, frame 0xA5 sent LSB-first -> data=0xA5, valid high exactly 1 cycle at t0+191, parity_err=0, frame_err=0.
REQ-036 rx low 5 cycles then high -> busy=1 from t0+1 to t0+10, then 0; valid never asserts.
REQ-037 PARITY=1, data 0x3C with parity bit 1 -> data=0x3C, parity_err=1; repeat with parity bit 0 -> parity_err=0.
REQ-038 Stop bit sent 0 on 0x55, next frame 0x0F back-to-back -> first word frame_err=1; second word 0x0F with frame_err=0.
REQ-039 ready=0, frames 0x11 then 0x22 -> data=0x22, overrun pulses 1 cycle, valid held; ready=1 -> valid=0 next cycle.
REQ-040 rst pulsed during data bit 3 -> all outputs 0 and busy=0 next cycle; following frame 0x81 received correctly.
